// File: rtl/serial_nibble_deserializer.sv
// serial_nibble_deserializer: MSB-first serial-to-word deserializer with output FIFO; even parity check when SERIAL_DESER_PARITY_EN is defined
module serial_nibble_deserializer #(
  parameter int WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overflow,
  output logic             parity_err,
  output logic [7:0]       frame_count
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SERIAL_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t           state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx, push_word;
  logic [WIDTH:0]   ext;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             take, bits_done, push, perr_set;
  always_comb begin
    take = start || state == SHIFT;
    ext = {sr, serial_in};
    sr_nx = start ? WIDTH'(serial_in) : take ? ext[WIDTH-1:0] : sr;
    cnt_nx = start ? CW'(1) : take ? cnt + CW'(1) : cnt;
    bits_done = take && cnt_nx == CW'(WIDTH);
`ifdef SERIAL_DESER_PARITY_EN
    state_nx = bits_done ? PARITY : take ? SHIFT : IDLE;
    push = state == PARITY && !start && !(^ext);
    perr_set = state == PARITY && !start && (^ext);
    push_word = sr;
`else
    state_nx = bits_done ? IDLE : take ? SHIFT : IDLE;
    push = bits_done;
    perr_set = 1'b0;
    push_word = sr_nx;
`endif
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      sr <= sr_nx;
      cnt <= cnt_nx;
    end
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      count;
  logic             full, pop, wr;
  // a pop on a full FIFO frees the slot the same-cycle push needs
  always_comb begin
    full = count == (AW+1)'(FIFO_DEPTH);
    pop = data_valid && data_ready;
    wr = push && (!full || pop);
  end
  always_ff @(posedge clk)
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
      parity_err <= 1'b0;
      frame_count <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= push_word;
        wp <= wp + AW'(1);
        frame_count <= frame_count + 8'd1;
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
      if (push && !wr) overflow <= 1'b1;
      if (perr_set) parity_err <= 1'b1;
    end
  assign data_out = mem[rp];
  assign data_valid = count != '0;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_serial_nibble_deserializer.sv
// tb_serial_nibble_deserializer: directed checks of framing, resync, FIFO overflow/drain and reset
module tb_serial_nibble_deserializer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       serial_in = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, busy, overflow, parity_err;
  logic [7:0] frame_count;
  int         checks = 0;
  int         fails = 0;

  serial_nibble_deserializer #(.WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .serial_in(serial_in),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .overflow(overflow), .parity_err(parity_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    serial_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
    serial_in = 1'b0;
  endtask

  // drives 8 data bits (plus correct even parity when enabled); returns in the last bit's cycle
  task automatic send_frame(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      start = (i == 7);
      serial_in = w[i];
    end
`ifdef SERIAL_DESER_PARITY_EN
    @(negedge clk);
    start = 1'b0;
    serial_in = ^w;
`endif
  endtask

  task automatic test_reset();
    do_reset();
    data_ready = 1'b0;
    send_frame(8'h5A);
    idle();
    checks++; if (data_out !== 8'h5A) begin fails++; $display("FAIL pre_reset_data got %h expected %h", data_out, 8'h5A); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = (i == 0);
      serial_in = 1'b1;
    end
    do_reset();
    checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data_out got %h expected %h", data_out, 8'h00); end
    checks++; if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b expected 0", data_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b expected 0", overflow); end
    checks++; if (parity_err !== 1'b0) begin fails++; $display("FAIL reset_parity_err got %b expected 0", parity_err); end
    checks++; if (frame_count !== 8'd0) begin fails++; $display("FAIL reset_frame_count got %0d expected 0", frame_count); end
    data_ready = 1'b1;
    send_frame(8'h96);
    idle();
    checks++; if (data_valid !== 1'b1 || data_out !== 8'h96) begin fails++; $display("FAIL post_reset_frame got valid=%b data=%h expected valid=1 data=96", data_valid, data_out); end
    checks++; if (frame_count !== 8'd1) begin fails++; $display("FAIL post_reset_count got %0d expected 1", frame_count); end
  endtask

  task automatic test_single();
    do_reset();
    data_ready = 1'b1;
    send_frame(8'hA5);
    checks++; if (data_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_last_bit got valid=%b busy=%b expected valid=0 busy=1", data_valid, busy); end
    idle();
    checks++; if (data_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b expected 1", data_valid); end
    checks++; if (data_out !== 8'hA5) begin fails++; $display("FAIL single_data got %h expected a5", data_out); end
    checks++; if (frame_count !== 8'd1) begin fails++; $display("FAIL single_count got %0d expected 1", frame_count); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_done got %b expected 0", busy); end
    idle();
    checks++; if (data_valid !== 1'b0) begin fails++; $display("FAIL single_valid_pulse got %b expected 0", data_valid); end
  endtask

  task automatic test_resync();
    do_reset();
    data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i == 0);
      serial_in = 1'b1;
    end
    send_frame(8'h3C);
    idle();
    checks++; if (data_valid !== 1'b1 || data_out !== 8'h3C) begin fails++; $display("FAIL resync_data got valid=%b data=%h expected valid=1 data=3c", data_valid, data_out); end
    checks++; if (frame_count !== 8'd1) begin fails++; $display("FAIL resync_count got %0d expected 1", frame_count); end
    checks++; if (overflow !== 1'b0 || parity_err !== 1'b0) begin fails++; $display("FAIL resync_flags got ovf=%b perr=%b expected 0 0", overflow, parity_err); end
    idle();
    checks++; if (data_valid !== 1'b0) begin fails++; $display("FAIL resync_single_word got valid=%b expected 0", data_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    data_ready = 1'b0;
    for (int w = 1; w <= 5; w++) send_frame(8'(w));
    idle();
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b expected 1", overflow); end
    checks++; if (frame_count !== 8'd4) begin fails++; $display("FAIL ovf_count got %0d expected 4", frame_count); end
    data_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (data_valid !== 1'b1 || data_out !== 8'(k)) begin fails++; $display("FAIL ovf_drain_%0d got valid=%b data=%h expected valid=1 data=%h", k, data_valid, data_out, 8'(k)); end
      @(negedge clk);
    end
    checks++; if (data_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty got valid=%b expected 0", data_valid); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b expected 1", overflow); end
    data_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    do_reset();
    data_ready = 1'b0;
    for (int w = 'h10; w <= 'h13; w++) send_frame(8'(w));
    send_frame(8'h14);
    data_ready = 1'b1;
    idle();
    data_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL fullpop_overflow got %b expected 0", overflow); end
    checks++; if (frame_count !== 8'd5) begin fails++; $display("FAIL fullpop_count got %0d expected 5", frame_count); end
    data_ready = 1'b1;
    for (int k = 'h11; k <= 'h14; k++) begin
      checks++; if (data_valid !== 1'b1 || data_out !== 8'(k)) begin fails++; $display("FAIL fullpop_drain got valid=%b data=%h expected valid=1 data=%h", data_valid, data_out, 8'(k)); end
      @(negedge clk);
    end
    checks++; if (data_valid !== 1'b0) begin fails++; $display("FAIL fullpop_empty got valid=%b expected 0", data_valid); end
    data_ready = 1'b0;
  endtask

`ifdef SERIAL_DESER_PARITY_EN
  task automatic test_parity();
    do_reset();
    data_ready = 1'b1;
    send_frame(8'hA5);
    idle();
    checks++; if (data_valid !== 1'b1 || data_out !== 8'hA5) begin fails++; $display("FAIL parity_good got valid=%b data=%h expected valid=1 data=a5", data_valid, data_out); end
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      start = (i == 7);
      serial_in = i[0] ? (i == 7 || i == 5) : (i == 2 || i == 0);
    end
    @(negedge clk);
    start = 1'b0;
    serial_in = 1'b1;
    idle();
    checks++; if (data_valid !== 1'b0) begin fails++; $display("FAIL parity_drop got valid=%b expected 0", data_valid); end
    checks++; if (parity_err !== 1'b1) begin fails++; $display("FAIL parity_err got %b expected 1", parity_err); end
    checks++; if (frame_count !== 8'd1) begin fails++; $display("FAIL parity_count got %0d expected 1", frame_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_resync();
    test_overflow();
    test_full_pop();
`ifdef SERIAL_DESER_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
